// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Contents:
//   state_t  : arbiter sequencing states
//   owner_t  : requester identity (CPU or loader/debug port)
//   DEF_*    : default parameter values
//   addr_misaligned : word-alignment test on the two low byte-address bits
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_MEM_LAT = 2;

   // A word access is legal only when the byte offset is zero.
   function automatic logic addr_misaligned(input logic [1:0] lsb);
      return (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req      [1:0] in  : request lines, bit 0 = CPU, bit 1 = debug port
//   ptr            in  : requester that wins a tie
//   grant    [1:0] out : one-hot grant (all zero when no request)
//   next_ptr       out : pointer value to store if the grant is taken
module arb_rr2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     ptr,
   output logic [1:0] grant,
   output owner_t     next_ptr
);

   // Pick a winner; the pointer always moves to the requester that lost.
   always_comb begin
      grant    = 2'b00;
      next_ptr = ptr;
      case (req)
         2'b01: begin
            grant    = 2'b01;
            next_ptr = OWN_DBG;
         end
         2'b10: begin
            grant    = 2'b10;
            next_ptr = OWN_CPU;
         end
         2'b11: begin
            if (ptr == OWN_CPU) begin
               grant    = 2'b01;
               next_ptr = OWN_DBG;
            end else begin
               grant    = 2'b10;
               next_ptr = OWN_CPU;
            end
         end
         default: begin
            grant    = 2'b00;
            next_ptr = ptr;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port, fixed-latency data memory
// between the CPU load/store path and the program loader/debug port.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/we/addr/wdata in  : CPU request, held until cpu_gnt
//   cpu_gnt/done/err/rdata out: registered handshake pulses and load data
//   cpu_stall             out : cpu_req & ~cpu_done (combinational)
//   dbg_*                     : same handshake for the debug port (no stall)
//   mem_en/we/addr/wdata  out : registered one-cycle memory strobe
//   mem_rdata             in  : valid MEM_LAT cycles after the mem_en cycle
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [31:0]       dbg_addr,
   input  logic [31:0]       dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic              dbg_err,
   output logic [31:0]       dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t           state_r;
   owner_t           ptr_r;
   owner_t           owner_r;
   logic             we_r;
   logic [CNT_W-1:0] cnt_r;

   logic [1:0]       req_s;
   logic [1:0]       grant_s;
   owner_t           next_ptr_s;
   owner_t           sel_own_s;
   logic             sel_we_s;
   logic [31:0]      sel_addr_s;
   logic [31:0]      sel_wdata_s;
   logic             unused_s;

   assign req_s     = {dbg_req, cpu_req};
   assign cpu_stall = cpu_req & ~cpu_done;

   // Upper byte-address bits lie outside the memory and are ignored.
   assign unused_s  = ^sel_addr_s[31:ADDR_W+2];

   arb_rr2 u_arb (
      .req      (req_s),
      .ptr      (ptr_r),
      .grant    (grant_s),
      .next_ptr (next_ptr_s)
   );

   // Route the winning requester's command fields to the latch stage.
   always_comb begin
      if (grant_s[1]) begin
         sel_own_s   = OWN_DBG;
         sel_we_s    = dbg_we;
         sel_addr_s  = dbg_addr;
         sel_wdata_s = dbg_wdata;
      end else begin
         sel_own_s   = OWN_CPU;
         sel_we_s    = cpu_we;
         sel_addr_s  = cpu_addr;
         sel_wdata_s = cpu_wdata;
      end
   end

   // Sequencer: arbitration, latency count and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         ptr_r     <= OWN_CPU;
         owner_r   <= OWN_CPU;
         we_r      <= 1'b0;
         cnt_r     <= '0;
         cpu_gnt   <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= 32'h0;
         dbg_gnt   <= 1'b0;
         dbg_done  <= 1'b0;
         dbg_err   <= 1'b0;
         dbg_rdata <= 32'h0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'h0;
      end else begin
         // Handshake and strobe outputs are single-cycle pulses.
         cpu_gnt  <= 1'b0;
         dbg_gnt  <= 1'b0;
         cpu_done <= 1'b0;
         dbg_done <= 1'b0;
         cpu_err  <= 1'b0;
         dbg_err  <= 1'b0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_s != 2'b00) begin
                  ptr_r     <= next_ptr_s;
                  owner_r   <= sel_own_s;
                  we_r      <= sel_we_s;
                  mem_addr  <= sel_addr_s[ADDR_W+1:2];
                  mem_wdata <= sel_wdata_s;
                  cpu_gnt   <= grant_s[0];
                  dbg_gnt   <= grant_s[1];
                  if (addr_misaligned(sel_addr_s[1:0])) begin
                     state_r <= ERR;
                  end else begin
                     state_r <= ACCESS;
                     mem_en  <= 1'b1;
                     mem_we  <= sel_we_s;
                     cnt_r   <= CNT_W'(MEM_LAT);
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               // Counter hits zero in the cycle mem_rdata is valid.
               if (cnt_r == '0) begin
                  state_r <= DONE;
                  if (owner_r == OWN_CPU) begin
                     cpu_done  <= 1'b1;
                     cpu_rdata <= we_r ? 32'h0 : mem_rdata;
                  end else begin
                     dbg_done  <= 1'b1;
                     dbg_rdata <= we_r ? 32'h0 : mem_rdata;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            ERR: begin
               state_r <= DONE;
               if (owner_r == OWN_CPU) begin
                  cpu_done  <= 1'b1;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= 32'h0;
               end else begin
                  dbg_done  <= 1'b1;
                  dbg_err   <= 1'b1;
                  dbg_rdata <= 32'h0;
               end
            end
            DONE: begin
               // The done pulse is on the outputs now; rearbitrate next cycle.
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int LAT0 = 2;

   typedef struct { int cyc; bit who; } gnt_t;
   typedef struct { int cyc; bit we; logic [9:0] addr; logic [31:0] wdata; } mem_t;
   typedef struct { int cyc; bit who; bit err; logic [31:0] rdata; } done_t;
   typedef struct { int cyc; bit val; } st_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   fin = 1'b0;

   // DUT 0 (MEM_LAT = 2)
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_gnt, cpu_done, cpu_err, cpu_stall;
   logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0, cpu_rdata;
   logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_gnt, dbg_done, dbg_err;
   logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0, dbg_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   // DUT 1 (MEM_LAT = 1)
   logic        cpu1_req = 1'b0, cpu1_gnt, cpu1_done, cpu1_err, cpu1_stall;
   logic [31:0] cpu1_addr = 32'h0, cpu1_rdata;
   logic        dbg1_req = 1'b0, dbg1_gnt, dbg1_done, dbg1_err;
   logic [31:0] dbg1_addr = 32'h0, dbg1_rdata;
   logic        mem1_en, mem1_we;
   logic [9:0]  mem1_addr;
   logic [31:0] mem1_wdata, mem1_rdata;

   gnt_t  gq[$];
   mem_t  mq[$];
   done_t dq[$];
   st_t   sq[$];
   int    g1q[$];
   mem_t  m1q[$];
   done_t d1q[$];
   logic [31:0] last_cpu = 32'h0, last_dbg = 32'h0;

   dmem_arbiter #(.ADDR_W(10), .MEM_LAT(2)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(10), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu1_req), .cpu_we(1'b0), .cpu_addr(cpu1_addr), .cpu_wdata(32'h0),
      .cpu_gnt(cpu1_gnt), .cpu_done(cpu1_done), .cpu_err(cpu1_err), .cpu_rdata(cpu1_rdata),
      .cpu_stall(cpu1_stall),
      .dbg_req(dbg1_req), .dbg_we(1'b0), .dbg_addr(dbg1_addr), .dbg_wdata(32'h0),
      .dbg_gnt(dbg1_gnt), .dbg_done(dbg1_done), .dbg_err(dbg1_err), .dbg_rdata(dbg1_rdata),
      .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
      .mem_rdata(mem1_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: data is driven only in the cycle it is valid, poison otherwise.
   logic [31:0] mem0 [0:1023];
   logic [31:0] mem1 [0:1023];
   bit          mem_ready = 1'b0;
   logic [1:0]  p0_v = 2'b00;
   logic [31:0] p0_d0 = 32'h0, p0_d1 = 32'h0;
   logic        p1_v = 1'b0;
   logic [31:0] p1_d = 32'h0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) begin
            mem0[i] <= 32'hA500_0000 | i;
            mem1[i] <= 32'hA500_0000 | i;
         end
         mem0[4]   <= 32'hDEAD_BEEF;
         mem1[4]   <= 32'hDEAD_BEEF;
         mem_ready <= 1'b1;
      end else begin
         if (mem_en && mem_we) mem0[mem_addr] <= mem_wdata;
         p0_v  <= {p0_v[0], mem_en && !mem_we};
         p0_d0 <= mem0[mem_addr];
         p0_d1 <= p0_d0;
         p1_v  <= mem1_en && !mem1_we;
         p1_d  <= mem1[mem1_addr];
      end
   end
   assign mem_rdata  = p0_v[1] ? p0_d1 : 32'hBAD0_BAD0;
   assign mem1_rdata = p1_v ? p1_d : 32'hBAD0_BAD0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor / scoreboard: the only process that compares.
   always @(negedge clk) begin
      gnt_t g; mem_t m; done_t d; st_t s; int c1; logic [31:0] z;
      if (!reset) begin
         z = cpu_rdata | dbg_rdata | mem_wdata | {22'h0, mem_addr} |
             {24'h0, cpu_gnt, cpu_done, cpu_err, dbg_gnt, dbg_done, dbg_err, mem_en, mem_we};
         chk("reset_outputs", z, 32'h0);
         last_cpu = 32'h0;
         last_dbg = 32'h0;
      end else begin
         if (cpu_gnt || dbg_gnt) begin
            chk("gnt_overlap", 32'(cpu_gnt & dbg_gnt), 32'h0);
            if (gq.size() == 0) chk("gnt_unexpected", 32'({dbg_gnt, cpu_gnt}), 32'h0);
            else begin
               g = gq.pop_front();
               chk("gnt_who", 32'(dbg_gnt), 32'(g.who));
               chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
            end
         end
         if (mem_we && !mem_en) chk("mem_we_stray", 32'(mem_we), 32'h0);
         if (mem_en) begin
            if (mq.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 32'h0);
            else begin
               m = mq.pop_front();
               chk("mem_cycle", 32'(cyc), 32'(m.cyc));
               chk("mem_we", 32'(mem_we), 32'(m.we));
               chk("mem_addr", 32'(mem_addr), 32'(m.addr));
               if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            end
         end
         if ((cpu_err && !cpu_done) || (dbg_err && !dbg_done))
            chk("err_without_done", 32'({dbg_err, cpu_err}), 32'({dbg_done, cpu_done}));
         if (cpu_done || dbg_done) begin
            chk("done_overlap", 32'(cpu_done & dbg_done), 32'h0);
            if (dq.size() == 0) chk("done_unexpected", 32'({dbg_done, cpu_done}), 32'h0);
            else begin
               d = dq.pop_front();
               chk("done_who", 32'(dbg_done), 32'(d.who));
               chk("done_cycle", 32'(cyc), 32'(d.cyc));
               chk("done_err", 32'(d.who ? dbg_err : cpu_err), 32'(d.err));
               chk("done_rdata", d.who ? dbg_rdata : cpu_rdata, d.rdata);
               if (d.who) begin
                  chk("cpu_rdata_hold", cpu_rdata, last_cpu);
                  last_dbg = d.rdata;
               end else begin
                  chk("dbg_rdata_hold", dbg_rdata, last_dbg);
                  last_cpu = d.rdata;
               end
            end
         end
         if (sq.size() != 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            chk("cpu_stall", 32'(cpu_stall), 32'(s.val));
         end
         // Second instance (MEM_LAT = 1)
         if (dbg1_gnt || dbg1_done || dbg1_err)
            chk("u1_dbg_activity", 32'({dbg1_gnt, dbg1_done, dbg1_err}), 32'h0);
         if (cpu1_gnt) begin
            if (g1q.size() == 0) chk("u1_gnt_unexpected", 32'(cpu1_gnt), 32'h0);
            else begin
               c1 = g1q.pop_front();
               chk("u1_gnt_cycle", 32'(cyc), 32'(c1));
            end
         end
         if (mem1_en) begin
            if (m1q.size() == 0) chk("u1_mem_en_unexpected", 32'(mem1_en), 32'h0);
            else begin
               m = m1q.pop_front();
               chk("u1_mem_cycle", 32'(cyc), 32'(m.cyc));
               chk("u1_mem_addr", 32'(mem1_addr), 32'(m.addr));
            end
         end
         if (cpu1_done) begin
            if (d1q.size() == 0) chk("u1_done_unexpected", 32'(cpu1_done), 32'h0);
            else begin
               d = d1q.pop_front();
               chk("u1_done_cycle", 32'(cyc), 32'(d.cyc));
               chk("u1_done_err", 32'(cpu1_err), 32'(d.err));
               chk("u1_done_rdata", cpu1_rdata, d.rdata);
            end
         end
      end
      if (fin) begin
         chk("gnt_left", 32'(gq.size()), 32'h0);
         chk("mem_left", 32'(mq.size()), 32'h0);
         chk("done_left", 32'(dq.size()), 32'h0);
         chk("stall_left", 32'(sq.size()), 32'h0);
         chk("u1_left", 32'(g1q.size() + m1q.size() + d1q.size()), 32'h0);
         $display("%0d/%0d checks passed", n_pass, n_chk);
         $finish;
      end
   end

   // Single access on DUT 0 from an idle arbiter; called #1 after a posedge.
   task automatic issue(input bit who, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata);
      int c0;
      c0 = cyc;
      if (who) begin
         dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
         sq.push_back('{c0, 1'b1});
         sq.push_back('{c0 + 1, 1'b1});
      end
      gq.push_back('{c0 + 1, who});
      if (!exp_err) begin
         mq.push_back('{c0 + 1, we, addr[11:2], wdata});
         dq.push_back('{c0 + LAT0 + 2, who, 1'b0, exp_rdata});
      end else begin
         dq.push_back('{c0 + 2, who, 1'b1, exp_rdata});
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (LAT0 + 1) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // CPU load word 4
      issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
      // Debug store to word 2
      issue(1'b1, 1'b1, 32'h8, 32'h1234_5678, 1'b0, 32'h0);

      // Both hold req: CPU, dbg, CPU, dbg with one access every 5 cycles
      c0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
      for (int k = 0; k < 4; k++) begin
         gq.push_back('{c0 + 1 + 5 * k, k[0]});
         mq.push_back('{c0 + 1 + 5 * k, 1'b0, k[0] ? 10'd2 : 10'd4, 32'h0});
         dq.push_back('{c0 + 4 + 5 * k, k[0], 1'b0, k[0] ? 32'h1234_5678 : 32'hDEAD_BEEF});
      end
      sq.push_back('{c0 + 3, 1'b1});
      sq.push_back('{c0 + 4, 1'b0});
      repeat (16) @(posedge clk);
      #1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // CPU reads back the debug store
      issue(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1234_5678);
      // Misaligned CPU load
      issue(1'b0, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0);

      // Reset during a CPU load: no done pulse may follow
      c0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      gq.push_back('{c0 + 1, 1'b0});
      mq.push_back('{c0 + 1, 1'b0, 10'd4, 32'h0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1234_5678);

      // MEM_LAT = 1: one-cycle dbg pulse during a busy CPU access is lost
      c0 = cyc;
      cpu1_req = 1'b1; cpu1_addr = 32'h10;
      g1q.push_back(c0 + 1);
      m1q.push_back('{c0 + 1, 1'b0, 10'd4, 32'h0});
      d1q.push_back('{c0 + 3, 1'b0, 1'b0, 32'hDEAD_BEEF});
      @(posedge clk); #1;
      dbg1_req = 1'b1; dbg1_addr = 32'h8;
      @(posedge clk); #1;
      cpu1_req = 1'b0;
      dbg1_req = 1'b0;
      repeat (6) @(posedge clk);
      #1 fin = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the CPU load/store path (requester 0) and the program loader/debug port (requester 1).
- Owns the memory handshake: fixed-latency access counting, a CPU stall request, and round-robin fairness between the two requesters.
- Sits between the datapath's memory stage and the data memory macro.

Parameters:
- ADDR_W, 10, memory word-address width (depth 2**ADDR_W words).
- MEM_LAT, 2, memory read latency in cycles; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_gnt  out  1  one-cycle pulse: request accepted.
- cpu_done  out  1  one-cycle pulse: access complete.
- cpu_err  out  1  valid with cpu_done: misaligned address.
- cpu_rdata  out  32  load data, valid with cpu_done.
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational).
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_err, dbg_rdata: same as the cpu_* ports, for requester 1.
- mem_en  out  1  memory access strobe, one cycle.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all gnt, done, err, mem_en and mem_we = 0.
  - rdata and mem_addr/mem_wdata registers = 0.
  - Round-robin pointer favours the CPU.
  - An in-flight access is abandoned with no done pulse. A write already strobed may have landed in memory.
- Every output is registered except cpu_stall and dbg_stall-free paths. There is no dbg stall output.
- State IDLE:
  - The arbiter samples both req lines.
  - If one is active, that requester wins.
  - If both are active, the requester not served last wins (pointer). The pointer updates on each grant.
  - On a win it latches the owner, we, addr and wdata, and moves to ACCESS (aligned address) or ERR (addr[1:0]!=0).
- State ACCESS:
  - The first cycle drives gnt_owner=1, mem_en=1 and mem_we=latched we. The latency counter loads MEM_LAT.
  - The counter decrements each cycle. When it reaches 0, mem_rdata is captured (cycle E+MEM_LAT, where E is the mem_en cycle). The state moves to DONE.
- State DONE:
  - done_owner=1 for one cycle.
  - rdata_owner = captured data for a load, 32'h0 for a store.
  - err=0. Next state is IDLE.
- State ERR:
  - gnt_owner=1 for one cycle, no mem_en.
  - The next cycle drives done_owner=1, err=1, rdata=0, then returns to IDLE.
- Latency from req sampled in cycle 0:
  - gnt and mem_en in cycle 1.
  - done in cycle MEM_LAT+2; load data is returned the same cycle.
  - Minimum spacing between back-to-back accesses: one idle cycle.
- Requester rules:
  - req must be held until gnt. Dropping req before gnt withdraws the request with no side effects.
  - addr, we and wdata are sampled only at the IDLE-exit edge. Changes afterwards are ignored.
  - req still high in the done cycle is a new request and is arbitrated in the following IDLE cycle.
- The non-owner's gnt, done and err stay 0 throughout. Its rdata holds its last value.
- Simultaneous requests every cycle alternate strictly: CPU, dbg, CPU, and so on.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE, ERR}.
  - owner enum {OWN_CPU, OWN_DBG}.
  - Default MEM_LAT and ADDR_W constants.
- Sub-module arb_rr2: two-way round-robin picker.
  - Inputs: req[1:0], pointer.
  - Outputs: grant one-hot and the next pointer. Purely combinational.

Test Plan:
- CPU load, MEM_LAT=2, addr=0x10, memory word 4 = 0xDEADBEEF → cpu_gnt and mem_en in cycle 1 with mem_addr=4, mem_we=0; cpu_done in cycle 4 with cpu_rdata=0xDEADBEEF.
- dbg store to addr=0x8 with wdata=0x12345678, then CPU load from 0x8 → mem_we=1 with mem_addr=2; the CPU then reads back 0x12345678; CPU rdata in the store's done cycle stays unchanged.
- Both requesters hold req continuously for 4 accesses → grant order CPU, dbg, CPU, dbg; no grant overlap; each done pulse goes to the owner only.
- CPU load at addr=0x6 → cpu_gnt in cycle 1, no mem_en; cpu_done=1 with cpu_err=1 and cpu_rdata=0 in cycle 2; cpu_stall=1 from cycle 0 to cycle 1.
- Assert reset in cycle 2 of a CPU load → all outputs 0 immediately with no cpu_done; after release, a dbg-only request is granted first cycle.
- MEM_LAT=1, dbg req pulsed for one cycle while a CPU access is busy → the dbg request is lost, with no dbg_gnt and no mem_en for dbg.
